// File: rtl/decoder_scan_sequencer_if.sv
// Bus bundle between the scan sequencer and its controller.
// master = controller (drives the scan controls), slave = sequencer.
interface decoder_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               oneshot;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic               A;
  logic               B;
  logic               en;
  logic               busy;
  logic               slot_done;
  logic               frame_done;

  modport master (
    output start, stop, oneshot, mask, dwell,
    input  A, B, en, busy, slot_done, frame_done
  );

  modport slave (
    input  start, stop, oneshot, mask, dwell,
    output A, B, en, busy, slot_done, frame_done
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Slot sequencer for a 2-to-4 enable decoder. Walks the enabled slots in
// ascending order, holds each one for a programmable dwell and blanks the
// enable between slots so the decoder outputs switch break-before-make.
module decoder_scan_sequencer #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  decoder_scan_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_ACTIVE
  } state_t;

  localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  state_t             state_q,      state_d;
  logic [1:0]         slot_q,       slot_d;
  logic [DWELL_W-1:0] dwell_lat_q,  dwell_lat_d;
  logic [DWELL_W-1:0] dwell_cnt_q,  dwell_cnt_d;
  logic [BLANK_W-1:0] blank_cnt_q,  blank_cnt_d;
  logic [1:0]         nxt_slot_q,   nxt_slot_d;
  logic               nxt_found_q,  nxt_found_d;
  logic               nxt_wrap_q,   nxt_wrap_d;
  logic               en_q,         en_d;
  logic               busy_q,       busy_d;
  logic               slot_done_q,  slot_done_d;
  logic               frame_done_q, frame_done_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [2:0]         sel;

  // Returns {found, index} of the first set mask bit after cur, wrapping
  // modulo 4 and ending on cur itself (a lone enabled slot finds itself).
  function automatic logic [2:0] search_next(input logic [1:0] cur,
                                             input logic [3:0] m);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    // Nearest offset is visited last so it wins.
    for (int i = 4; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

  // Next-state, counters and registered-output decode.
  // The next slot is chosen on the edge that enters the final ACTIVE cycle,
  // so slot_done/frame_done can be registered and land in that same cycle.
  always_comb begin
    // NOTE: every always_comb target gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d      = state_q;
    slot_d       = slot_q;
    dwell_lat_d  = dwell_lat_q;
    dwell_cnt_d  = dwell_cnt_q;
    blank_cnt_d  = blank_cnt_q;
    nxt_slot_d   = nxt_slot_q;
    nxt_found_d  = nxt_found_q;
    nxt_wrap_d   = nxt_wrap_q;
    slot_done_d  = 1'b0;
    frame_done_d = 1'b0;
    sel          = '0;

    if (bus.stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && (bus.mask != 4'b0000)) begin
            sel         = search_next(2'd3, bus.mask);
            slot_d      = sel[1:0];
            dwell_lat_d = dwell_eff;
            blank_cnt_d = BLANK_W'(BLANK_CYC - 1);
            state_d     = S_BLANK;
          end
        end
        S_BLANK: begin
          if (blank_cnt_q == '0) begin
            dwell_cnt_d = dwell_lat_q;
            state_d     = S_ACTIVE;
          end else begin
            blank_cnt_d = blank_cnt_q - BLANK_W'(1);
          end
        end
        S_ACTIVE: begin
          if (dwell_cnt_q > DWELL_W'(1)) begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          end else begin
            dwell_cnt_d = '0;
            if (!nxt_found_q || (nxt_wrap_q && bus.oneshot)) begin
              state_d = S_IDLE;
            end else begin
              slot_d      = nxt_slot_q;
              dwell_lat_d = dwell_eff;
              blank_cnt_d = BLANK_W'(BLANK_CYC - 1);
              state_d     = S_BLANK;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if ((state_d == S_ACTIVE) && (dwell_cnt_d == DWELL_W'(1))) begin
      sel          = search_next(slot_q, bus.mask);
      nxt_found_d  = sel[2];
      nxt_slot_d   = sel[1:0];
      nxt_wrap_d   = sel[1:0] <= slot_q;
      slot_done_d  = 1'b1;
      frame_done_d = sel[2] && (sel[1:0] <= slot_q);
    end

    en_d   = (state_d == S_ACTIVE);
    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs.
  // NOTE: every flop here is control state, so all are cleared by the async
  // reset; there is no storage array that could be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      dwell_lat_q  <= '0;
      dwell_cnt_q  <= '0;
      blank_cnt_q  <= '0;
      nxt_slot_q   <= '0;
      nxt_found_q  <= 1'b0;
      nxt_wrap_q   <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      slot_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      slot_q       <= slot_d;
      dwell_lat_q  <= dwell_lat_d;
      dwell_cnt_q  <= dwell_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
      nxt_slot_q   <= nxt_slot_d;
      nxt_found_q  <= nxt_found_d;
      nxt_wrap_q   <= nxt_wrap_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      slot_done_q  <= slot_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.A          = slot_q[1];
  assign bus.B          = slot_q[0];
  assign bus.en         = en_q;
  assign bus.busy       = busy_q;
  assign bus.slot_done  = slot_done_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench for decoder_scan_sequencer: table of one-shot frames
// plus hand-written sequences for continuous, abort, corner and reset cases.
module tb_decoder_scan_sequencer;

  localparam int DWELL_W   = 8;
  localparam int BLANK_CYC = 1;

  logic clk = 1'b0;
  logic rst_n;

  decoder_scan_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

  decoder_scan_sequencer #(
    .DWELL_W  (DWELL_W),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      mask;
    logic [7:0]      dwell;
    logic [2:0]      n;
    logic [3:0][1:0] order;
    logic [9:0]      busy;
  } vec_t;

  typedef struct packed {
    logic [1:0] slot;
    logic       fd;
    logic [8:0] len;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int         en_run    = 0;
  int         gap       = 0;
  int         busy_cnt  = 0;
  int         popped    = 0;
  logic [1:0] ab_rise   = 2'd0;
  logic       ab_glitch = 1'b0;
  int         y_low[4];

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: called once per cycle at the falling edge.
  task automatic sample();
    exp_t e;
    if (!rst_n) begin
      en_run = 0;
      gap    = 0;
      return;
    end
    if (bus.en) begin
      y_low[{bus.A, bus.B}]++;
      if (en_run == 0) begin
        ab_rise   = {bus.A, bus.B};
        ab_glitch = 1'b0;
        check("blank_gap", gap, BLANK_CYC);
        gap = 0;
      end else if ({bus.A, bus.B} != ab_rise) begin
        ab_glitch = 1'b1;
      end
      en_run++;
    end else begin
      en_run = 0;
      if (bus.busy) gap++;
      else          gap = 0;
    end
    if (bus.slot_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_slot_done: got slot %0d, expected no slot_done", {bus.A, bus.B});
      end else begin
        e = sb.pop_front();
        popped++;
        check("slot_ab", int'({bus.A, bus.B}), int'(e.slot));
        check("frame_done", int'(bus.frame_done), int'(e.fd));
        check("en_len", en_run, int'(e.len));
        check("ab_stable", int'(ab_glitch), 0);
      end
    end else begin
      check("frame_without_slot", int'(bus.frame_done), 0);
    end
    if (bus.busy) busy_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic push(input logic [1:0] slot, input logic fd, input int dwell);
    exp_t e;
    e.slot = slot;
    e.fd   = fd;
    e.len  = 9'((dwell == 0) ? 1 : dwell);
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", int'(bus.busy), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    bus.mask    = v.mask;
    bus.dwell   = v.dwell;
    bus.oneshot = 1'b1;
    for (int i = 0; i < int'(v.n); i++) push(v.order[i], i == int'(v.n) - 1, int'(v.dwell));
    base = busy_cnt;
    pulse_start();
    wait_idle(2000);
    check("busy_cycles", busy_cnt - base, int'(v.busy));
    check("sb_drained", sb.size(), 0);
  endtask

  function automatic vec_t mk(input logic [3:0] mask, input logic [7:0] dwell,
                              input logic [2:0] n, input logic [1:0] o0,
                              input logic [1:0] o1, input logic [1:0] o2,
                              input logic [1:0] o3, input logic [9:0] busy);
    vec_t v;
    v.mask  = mask;
    v.dwell = dwell;
    v.n     = n;
    v.order = {o3, o2, o1, o0};
    v.busy  = busy;
    return v;
  endfunction

  initial begin
    int base;
    int n;

    // One-shot frames: mask, dwell, slot count, slot order, busy cycles.
    vecs[0] = mk(4'b1111, 8'd3,   3'd4, 2'd0, 2'd1, 2'd2, 2'd3, 10'd16);
    vecs[1] = mk(4'b1010, 8'd2,   3'd2, 2'd1, 2'd3, 2'd0, 2'd0, 10'd6);
    vecs[2] = mk(4'b0100, 8'd0,   3'd1, 2'd2, 2'd0, 2'd0, 2'd0, 10'd2);
    vecs[3] = mk(4'b1001, 8'd1,   3'd2, 2'd0, 2'd3, 2'd0, 2'd0, 10'd4);
    vecs[4] = mk(4'b0110, 8'd255, 3'd2, 2'd1, 2'd2, 2'd0, 2'd0, 10'd512);
    vecs[5] = mk(4'b1000, 8'd4,   3'd1, 2'd3, 2'd0, 2'd0, 2'd0, 10'd5);

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.oneshot = 1'b1;
    bus.mask    = 4'b0000;
    bus.dwell   = '0;
    for (int i = 0; i < 4; i++) y_low[i] = 0;
    tick();
    tick();
    check("rst_A", int'(bus.A), 0);
    check("rst_B", int'(bus.B), 0);
    check("rst_en", int'(bus.en), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_slot_done", int'(bus.slot_done), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // Continuous 1,3,1,3,...; switch to one-shot during the third frame.
    for (int i = 0; i < 4; i++) y_low[i] = 0;
    bus.mask    = 4'b1010;
    bus.dwell   = 8'd2;
    bus.oneshot = 1'b0;
    for (int f = 0; f < 3; f++) begin
      push(2'd1, 1'b0, 2);
      push(2'd3, 1'b1, 2);
    end
    base   = busy_cnt;
    popped = 0;
    pulse_start();
    n = 0;
    while (popped < 5 && n < 200) begin
      tick();
      n++;
    end
    check("cont_progress", popped, 5);
    bus.oneshot = 1'b1;
    wait_idle(200);
    check("cont_busy_cycles", busy_cnt - base, 18);
    check("cont_sb_drained", sb.size(), 0);
    check("y0_never_low", y_low[0], 0);
    check("y2_never_low", y_low[2], 0);
    check("y1_low_cycles", y_low[1], 6);
    check("y3_low_cycles", y_low[3], 6);
    tick();

    // Stop in the second ACTIVE cycle of slot 1.
    bus.mask    = 4'b1111;
    bus.dwell   = 8'd5;
    bus.oneshot = 1'b1;
    push(2'd0, 1'b0, 5);
    pulse_start();
    n = 0;
    while (!(bus.en && {bus.A, bus.B} == 2'd1) && n < 100) begin
      tick();
      n++;
    end
    check("reached_slot1", int'(bus.en && {bus.A, bus.B} == 2'd1), 1);
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_en", int'(bus.en), 0);
    check("stop_busy", int'(bus.busy), 0);
    check("stop_sb_drained", sb.size(), 0);
    for (int i = 0; i < 8; i++) tick();
    run_vec(mk(4'b1111, 8'd1, 3'd4, 2'd0, 2'd1, 2'd2, 2'd3, 10'd8));
    tick();

    // start and stop together: stop wins.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("start_stop_busy", int'(bus.busy), 0);
    tick();
    check("start_stop_en", int'(bus.en), 0);

    // start with an empty mask.
    bus.mask = 4'b0000;
    pulse_start();
    check("mask0_busy", int'(bus.busy), 0);
    tick();
    check("mask0_busy_later", int'(bus.busy), 0);

    // Mask cleared (and dwell changed) during ACTIVE of slot 0.
    bus.mask    = 4'b1111;
    bus.dwell   = 8'd4;
    bus.oneshot = 1'b0;
    push(2'd0, 1'b0, 4);
    base = busy_cnt;
    pulse_start();
    n = 0;
    while (!bus.en && n < 50) begin
      tick();
      n++;
    end
    bus.mask  = 4'b0000;
    bus.dwell = 8'd9;
    wait_idle(100);
    check("mask_clr_busy_cycles", busy_cnt - base, 5);
    check("mask_clr_sb_drained", sb.size(), 0);
    tick();

    // Async reset while slot 2 is enabled.
    bus.mask    = 4'b1111;
    bus.dwell   = 8'd3;
    bus.oneshot = 1'b1;
    push(2'd0, 1'b0, 3);
    push(2'd1, 1'b0, 3);
    pulse_start();
    n = 0;
    while (!(bus.en && {bus.A, bus.B} == 2'd2) && n < 100) begin
      tick();
      n++;
    end
    check("reached_slot2", int'(bus.en && {bus.A, bus.B} == 2'd2), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en", int'(bus.en), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_A", int'(bus.A), 0);
    check("arst_B", int'(bus.B), 0);
    check("arst_slot_done", int'(bus.slot_done), 0);
    check("arst_frame_done", int'(bus.frame_done), 0);
    check("arst_sb_drained", sb.size(), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_busy", int'(bus.busy), 0);
    check("post_rst_en", int'(bus.en), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_scan_sequencer.md
# decoder_scan_sequencer

- Registered, free-running or one-shot slot sequencer that drives the select inputs `A`, `B` and `en` of the downstream 2-to-4 enable decoder.
- Steps through the four decoder outputs in ascending order, skipping masked slots.
- Holds each slot enabled for a programmable dwell and inserts a blanking gap with `en` low between slots.
- Guarantees break-before-make: the decoder's active-low outputs never glitch between two slots.

## Interface
Parameters:
- `DWELL_W`, 8: width of the dwell-count input.
- `BLANK_CYC`, 1: cycles `en` is held low before each slot is enabled; legal range ≥ 1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: level-sampled; begins a scan from IDLE.
- `stop` input 1: level-sampled; aborts the scan and returns to IDLE.
- `oneshot` input 1: 1 = stop after one frame, 0 = repeat frames. Sampled at each frame wrap.
- `mask` input 4: slot enable, bit k = slot k with {A,B} = k. Sampled at each slot selection.
- `dwell` input DWELL_W: active cycles per slot. Sampled on entry to BLANK; 0 is treated as 1.
- `A` output 1: select MSB to the decoder.
- `B` output 1: select LSB to the decoder.
- `en` output 1: decoder enable.
- `busy` output 1: high whenever the state is not IDLE.
- `slot_done` output 1: one-cycle pulse in the last ACTIVE cycle of each slot.
- `frame_done` output 1: one-cycle pulse in the last ACTIVE cycle of the final enabled slot of a frame.

## Operation
- States are IDLE, BLANK and ACTIVE. All outputs are registered.
- Reset values: `A`=0, `B`=0, `en`=0, `busy`=0, `slot_done`=0, `frame_done`=0, state IDLE, counters 0.
- **IDLE**
  - `en`=0; `A`/`B` hold their last value.
  - On `start`=1 with `stop`=0 and `mask`≠0, select the lowest set mask bit, load {A,B}, latch the dwell, and go to BLANK.
  - If `mask`=0, stay in IDLE.
- **BLANK**
  - `en`=0 for exactly BLANK_CYC cycles, then go to ACTIVE.
- **ACTIVE**
  - `en`=1 for exactly max(dwell,1) cycles.
  - In the last cycle, pulse `slot_done`, then search `mask` upward from the current slot+1 with wrap modulo 4.
  - A wrap occurs when the next slot index is ≤ the current index, which includes a single enabled slot.
  - On wrap: pulse `frame_done`. If `oneshot`=1, go to IDLE; otherwise go to BLANK with the next slot.
  - No wrap: go to BLANK with the next slot.
  - If `mask`=0 at selection: go to IDLE with no `frame_done`; `slot_done` is still pulsed.
- **Addressing**
  - `A` and `B` change only on the transition into BLANK, so they are always stable while `en`=1.
- **Stop and start**
  - `stop`=1 in any state: next cycle `en`=0, state IDLE. No `slot_done`/`frame_done` is issued for the aborted slot.
  - `stop` has priority over `start` in the same cycle.
  - `start` while busy is ignored.
- **Dwell counter**
  - Width is DWELL_W. It counts down from the latched dwell and does not wrap; dwell = 2^DWELL_W−1 is legal.

## Timing
- `start` sampled high at edge t: `busy`=1 and {A,B} valid from t+1; `en` rises at t+1+BLANK_CYC.
- Slot period is BLANK_CYC + max(dwell,1) cycles. Full-mask frame period is 4× that.
- `slot_done` and `frame_done` are high in the same cycle as the final `en`=1 cycle; `en` falls the next cycle.
- For oneshot, `busy` falls in the cycle after `frame_done`.
- Reset asserted mid-slot: `en` and all pulses drop immediately (asynchronously), with no partial-slot output after release.
- `mask`/`dwell` changes during ACTIVE do not affect the current slot.

## Test plan
- **Full frame:** reset, `mask`=4'b1111, `dwell`=3, BLANK_CYC=1, `oneshot`=1, `start` one cycle.
  - Expect {A,B} = 0,1,2,3, each with `en` high 3 cycles after 1 low cycle.
  - Four `slot_done` pulses, `frame_done` with slot 3, then IDLE; total 16 cycles.
- **Masked continuous:** `mask`=4'b1010, `oneshot`=0, `dwell`=2.
  - Expect slots 1,3,1,3…, with `frame_done` on every slot-3 completion.
  - Decoder outputs Y1/Y3 alternate low; Y0/Y2 stay high.
- **Dwell 0 and single slot:** `dwell`=0, `mask`=4'b0100.
  - Expect `en` high 1 cycle per slot with {A,B}=2.
  - `slot_done` and `frame_done` pulse together every 2 cycles.
- **Stop abort:** `stop`=1 in the 2nd ACTIVE cycle of slot 1 (`dwell`=5).
  - Expect `en`=0 and `busy`=0 next cycle, no `slot_done`; a later `start` restarts from slot 0.
- **Corner cases:**
  - `start`+`stop` in the same cycle → stays IDLE.
  - `start` with `mask`=0 → stays IDLE.
  - Mask cleared during ACTIVE → IDLE after the slot with `slot_done` only.
- **Async reset:** assert `rst_n`=0 while `en`=1 between clock edges.
  - Expect `en`, `busy`, `A`, `B` = 0 without waiting for a clock edge.
